rbs_serial_subtractor: RTL and testbench

//  Multi-cycle ripple-borrow subtractor: diff = a - b - bin over WIDTH bits,

---
 rtl/rbs_serial_subtractor.sv | 138 +++++++++++++
 tb/tb_rbs_serial_subtractor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rbs_serial_subtractor.sv
// Multi-cycle ripple-borrow subtractor: diff = a - b - bin, CHUNK bits per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module rbs_serial_subtractor #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_width_check
            $error("rbs_serial_subtractor: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              brw_q, brw_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              done_q, done_d;
`ifdef SUB_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0]  a_k, b_k;
    logic [CHUNK:0]    sub_k;
    logic              last;

    // Current chunk with one extra bit so the MSB of the result is the borrow.
    always_comb begin
        a_k   = a_q[cnt_q*CHUNK +: CHUNK];
        b_k   = b_q[cnt_q*CHUNK +: CHUNK];
        sub_k = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK{1'b0}}, brw_q};
        last  = (cnt_q == CW'(N-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
`ifdef SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        brw_d  = brw_q;
        a_d    = a_q;
        b_d    = b_q;
        diff_d = diff_q;
        bout_d = bout_q;
        done_d = 1'b0;
`ifdef SUB_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                a_d   = a;
                b_d   = b;
                brw_d = bin;
                cnt_d = '0;
            end
        end else begin
            diff_d[cnt_q*CHUNK +: CHUNK] = sub_k[CHUNK-1:0];
            brw_d = sub_k[CHUNK];
            cnt_d = last ? '0 : cnt_q + CW'(1);
            if (last) begin
                bout_d = sub_k[CHUNK];
                done_d = 1'b1;
`ifdef SUB_OVF_EN
                // Operand signs differ and the result sign disagrees with the minuend.
                ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_k[CHUNK-1] != a_q[WIDTH-1]);
`endif
            end
        end
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        diff = diff_q;
        bout = bout_q;
`ifdef SUB_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_rbs_serial_subtractor.sv
// Directed and randomized checks for rbs_serial_subtractor (WIDTH=100, CHUNK=10).
module tb_rbs_serial_subtractor;

    localparam int W = 100;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         bin;
    logic         busy, done, bout;
    logic [W-1:0] diff;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    rbs_serial_subtractor #(.WIDTH(W), .CHUNK(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Launch one operation and check latency, diff and bout against given expectations.
    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input logic [W-1:0] ediff, input logic ebout);
        int cyc;
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb_; bin = ~tbin;
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL %s busy_after_start: got %b want 1", nm, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc !== N) begin
            fails++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, N);
        end
        tests++;
        if (diff !== ediff || bout !== ebout) begin
            fails++;
            $display("FAIL %s result: got diff=%h bout=%b want diff=%h bout=%b",
                     nm, diff, bout, ediff, ebout);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL %s done_pulse: got done=%b busy=%b want 0 0", nm, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b diff=%h bout=%b want 0 0 0 0",
                     busy, done, diff, bout);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] ones;
        logic [W-1:0] t;
        ones = '1;
        run_op("sub_5_3", 100'd5, 100'd3, 1'b0, 100'd2, 1'b0);
        run_op("sub_0_1", 100'd0, 100'd1, 1'b0, ones, 1'b1);
        run_op("borrow_chunk", 100'd1024, 100'd1, 1'b0, 100'h3FF, 1'b0);
        t = 100'h123;
        run_op("equal_bin", t, t, 1'b1, ones, 1'b1);
    endtask

    task automatic test_back_to_back();
        int ndone;
        int cyc;
        @(negedge clk);
        a = 100'd50; b = 100'd8; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            if (c == 3 || c == 7) begin
                a = 100'd900; b = 100'd1; bin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        tests++;
        if (ndone !== 1 || done !== 1'b1 || diff !== 100'd42 || bout !== 1'b0) begin
            fails++;
            $display("FAIL ignore_start_busy: got pulses=%0d done=%b diff=%h bout=%b want 1 1 2a 0",
                     ndone, done, diff, bout);
        end
        // Start in the done cycle must be accepted.
        a = 100'd7; b = 100'd9; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL start_in_done: got done=%b busy=%b want 0 1", done, busy);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc !== N || diff !== {W{1'b1}} - 100'd1 || bout !== 1'b1) begin
            fails++;
            $display("FAIL second_op: got lat=%0d diff=%h bout=%b want %0d fff..fe 1",
                     cyc, diff, bout, N);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int ndone;
        @(negedge clk);
        a = 100'd77; b = 100'd3; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0) begin
            fails++;
            $display("FAIL reset_abort: got busy=%b done=%b diff=%h bout=%b want 0 0 0 0",
                     busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (N + 3) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        tests++;
        if (ndone !== 0) begin
            fails++; $display("FAIL abort_no_done: got %0d active cycles want 0", ndone);
        end
        run_op("after_abort", 100'd300, 100'd45, 1'b1, 100'd254, 1'b0);
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] m;
        m = '0; m[W-1] = 1'b1;
        run_op("ovf_min", m, 100'd1, 1'b0, m - 100'd1, 1'b0);
        tests++;
        if (ovf !== 1'b1) begin
            fails++; $display("FAIL ovf_set: got %b want 1", ovf);
        end
        run_op("ovf_none", 100'd7, 100'd2, 1'b0, 100'd5, 1'b0);
        tests++;
        if (ovf !== 1'b0) begin
            fails++; $display("FAIL ovf_clear: got %b want 0", ovf);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rbin;
        logic [W:0]   ref_v;
        for (int i = 0; i < 1000; i++) begin
            ra   = W'({$urandom, $urandom, $urandom, $urandom});
            rb   = W'({$urandom, $urandom, $urandom, $urandom});
            if (i % 7 == 0) rb = ra;
            rbin = 1'($urandom);
            ref_v = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
            run_op("random", ra, rb, rbin, ref_v[W-1:0], ref_v[W]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_abort();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
